// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester/datapath bus bundle for alu_arbiter
//
// Purpose: groups the two requester handshakes, the result/busy status and
// the shared-datapath link into one bundle.
// Signals:
//   req_x, in_x[7:0], op_x[1:0]  requester x operation request (x = a, b)
//   ack_x, done_x                per-requester accept / completion pulses
//   result[8:0], busy            last completed result, not-idle flag
//   dp_in[7:0], dp_op[1:0]       operand / opcode to the shared datapath
//   dp_out[8:0]                  registered output of the shared datapath
// Modports: slave = arbiter side, master = requesters + datapath side.
interface alu_arbiter_if;
  logic       req_a;
  logic [7:0] in_a;
  logic [1:0] op_a;
  logic       ack_a;
  logic       done_a;

  logic       req_b;
  logic [7:0] in_b;
  logic [1:0] op_b;
  logic       ack_b;
  logic       done_b;

  logic [8:0] result;
  logic       busy;

  logic [7:0] dp_in;
  logic [1:0] dp_op;
  logic [8:0] dp_out;

  modport slave (
    input  req_a, in_a, op_a, req_b, in_b, op_b, dp_out,
    output ack_a, done_a, ack_b, done_b, result, busy, dp_in, dp_op
  );

  modport master (
    output req_a, in_a, op_a, req_b, in_b, op_b, dp_out,
    input  ack_a, done_a, ack_b, done_b, result, busy, dp_in, dp_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter for a shared ALU datapath
//
// Purpose: accepts one operation at a time from requester A or B, drives
// the shared datapath for one operation (IDLE -> ISSUE -> EXEC -> CAPT),
// then publishes the datapath output as result with a done pulse to the
// owner. Ties are broken round-robin.
// Ports:
//   i_clk  clock, all state changes on the rising edge
//   i_rst  synchronous active-high reset
//   bus    alu_arbiter_if.slave (requester handshakes, status, datapath link)
module alu_arbiter (
  input  logic         i_clk,
  input  logic         i_rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_owner_b;   // 1: current operation belongs to B
  logic       r_last_b;    // 1: B was granted most recently
  logic       r_ack_a;
  logic       r_ack_b;
  logic       r_done_a;
  logic       r_done_b;
  logic       r_busy;
  logic [8:0] r_result;
  logic [7:0] r_dp_in;     // doubles as the latched operand
  logic [1:0] r_dp_op;     // doubles as the latched opcode

  logic       w_any_req;
  logic       w_grant_b;

  // Grant choice for an IDLE cycle: a lone request wins outright; on a tie
  // the requester that was not granted last wins.
  always_comb begin
    w_any_req = bus.req_a | bus.req_b;
    w_grant_b = 1'b0;
    if (bus.req_a && bus.req_b) begin
      w_grant_b = ~r_last_b;
    end else begin
      w_grant_b = bus.req_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;   // so that A wins the first tie
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_done_a  <= 1'b0;
      r_done_b  <= 1'b0;
      r_busy    <= 1'b0;
      r_result  <= 9'd0;
      r_dp_in   <= 8'd0;
      r_dp_op   <= 2'd0;
    end else begin
      // Handshake outputs are single-cycle pulses by default.
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            // Operands are captured here only, so requester changes after
            // the grant cannot disturb the operation in flight.
            r_dp_in   <= w_grant_b ? bus.in_b : bus.in_a;
            r_dp_op   <= w_grant_b ? bus.op_b : bus.op_a;
            r_owner_b <= w_grant_b;
            r_last_b  <= w_grant_b;
            r_ack_a   <= ~w_grant_b;
            r_ack_b   <= w_grant_b;
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end

        // Datapath samples dp_in at the ISSUE -> EXEC edge.
        ST_ISSUE: r_state <= ST_EXEC;

        // Datapath output register loads at the EXEC -> CAPT edge.
        ST_EXEC: r_state <= ST_CAPT;

        ST_CAPT: begin
          r_result <= bus.dp_out;
          r_done_a <= ~r_owner_b;
          r_done_b <= r_owner_b;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_a  = r_ack_a;
  assign bus.ack_b  = r_ack_b;
  assign bus.done_a = r_done_a;
  assign bus.done_b = r_done_b;
  assign bus.busy   = r_busy;
  assign bus.result = r_result;
  assign bus.dp_in  = r_dp_in;
  assign bus.dp_op  = r_dp_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_arbiter_if bus();

  alu_arbiter u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared datapath model: operand register, then output register that
  // applies the live opcode at its edge.
  logic [7:0] dp_reg = 8'd0;

  function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [1:0] op);
    logic [8:0] pc;
    case (op)
      2'd0: return {1'b0, x};
      2'd1: return {1'b0, x} + 9'd2;
      2'd2: return {x, 1'b0};
      default: begin
        pc = 9'd0;
        for (int i = 0; i < 8; i++) pc = pc + {8'd0, x[i]};
        return pc;
      end
    endcase
  endfunction

  always_ff @(posedge clk) begin
    dp_reg     <= bus.dp_in;
    bus.dp_out <= alu_f(dp_reg, bus.dp_op);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.in_a = 8'd0; bus.op_a = 2'd0;
    bus.req_b = 1'b0; bus.in_b = 8'd0; bus.op_b = 2'd0;
  endtask

  // One complete operation starting at a negedge with the DUT in IDLE.
  task automatic do_txn(input logic ra, input logic rb,
                        input logic [7:0] ia, input logic [1:0] oa,
                        input logic [7:0] ib, input logic [1:0] ob,
                        input logic exp_b, input logic [8:0] exp_res);
    logic [7:0] exp_in;
    logic [1:0] exp_op;
    exp_in = exp_b ? ib : ia;
    exp_op = exp_b ? ob : oa;
    bus.req_a = ra; bus.in_a = ia; bus.op_a = oa;
    bus.req_b = rb; bus.in_b = ib; bus.op_b = ob;
    @(negedge clk);
    check("ack_a", bus.ack_a, !exp_b);
    check("ack_b", bus.ack_b, exp_b);
    check("busy_issue", bus.busy, 1);
    check("dp_in_issue", bus.dp_in, exp_in);
    check("dp_op_issue", bus.dp_op, exp_op);
    // Withdraw and disturb operands after the accept.
    bus.req_a = 1'b0; bus.in_a = 8'd0; bus.op_a = ~oa;
    bus.req_b = 1'b0; bus.in_b = 8'd0; bus.op_b = ~ob;
    @(negedge clk);
    @(negedge clk);
    check("no_done_early", {bus.done_a, bus.done_b}, 0);
    check("busy_capt", bus.busy, 1);
    @(negedge clk);
    check("done_a", bus.done_a, !exp_b);
    check("done_b", bus.done_b, exp_b);
    check("result", bus.result, exp_res);
    check("busy_idle", bus.busy, 0);
    check("dp_in_hold", bus.dp_in, exp_in);
  endtask

  typedef struct {
    logic       ra, rb;
    logic [7:0] ia;
    logic [1:0] oa;
    logic [7:0] ib;
    logic [1:0] ob;
    logic       exp_b;
    logic [8:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int rr_n;
    int overlap;
    logic       rr_who[4];
    logic [8:0] rr_res[4];
    int         rr_cyc[4];

    //             ra    rb    ia      oa    ib      ob    exp_b exp_res
    vecs[0] = '{1'b1, 1'b0, 8'd9,   2'd1, 8'd0,   2'd0, 1'b0, 9'd11};
    vecs[1] = '{1'b0, 1'b1, 8'd0,   2'd0, 8'd143, 2'd3, 1'b1, 9'd5};
    vecs[2] = '{1'b1, 1'b1, 8'd200, 2'd2, 8'd3,   2'd1, 1'b0, 9'd400};
    vecs[3] = '{1'b1, 1'b1, 8'd4,   2'd0, 8'd255, 2'd1, 1'b1, 9'd257};
    vecs[4] = '{1'b1, 1'b0, 8'd255, 2'd3, 8'd0,   2'd0, 1'b0, 9'd8};
    vecs[5] = '{1'b1, 1'b1, 8'd77,  2'd1, 8'd0,   2'd0, 1'b1, 9'd0};
    vecs[6] = '{1'b1, 1'b1, 8'd128, 2'd2, 8'd9,   2'd3, 1'b0, 9'd256};
    vecs[7] = '{1'b0, 1'b1, 8'd0,   2'd0, 8'd7,   2'd2, 1'b1, 9'd14};
    vecs[8] = '{1'b0, 1'b1, 8'd0,   2'd0, 8'd15,  2'd3, 1'b1, 9'd4};

    // Reset with both requests already high: nothing may be granted.
    idle_inputs();
    bus.req_a = 1'b1; bus.in_a = 8'd9;   bus.op_a = 2'd2;
    bus.req_b = 1'b1; bus.in_b = 8'd143; bus.op_b = 2'd3;
    repeat (3) @(negedge clk);
    check("rst_ack", {bus.ack_a, bus.ack_b}, 0);
    check("rst_done", {bus.done_a, bus.done_b}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_dp_in", bus.dp_in, 0);
    check("rst_dp_op", bus.dp_op, 0);

    // Tie after reset: A first (result 18), then B at E4 (result 5).
    rst = 1'b0;
    @(negedge clk);
    check("tie_ack_a", bus.ack_a, 1);
    check("tie_ack_b", bus.ack_b, 0);
    bus.req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tie_no_done", {bus.done_a, bus.done_b}, 0);
    @(negedge clk);
    check("tie_done_a", {bus.done_a, bus.done_b}, 2'b10);
    check("tie_res_a", bus.result, 18);
    @(negedge clk);
    check("tie_ack_b_e4", {bus.ack_a, bus.ack_b}, 2'b01);
    bus.req_b = 1'b0;
    repeat (3) @(negedge clk);
    check("tie_done_b", {bus.done_a, bus.done_b}, 2'b01);
    check("tie_res_b", bus.result, 5);

    // Table-driven operations.
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].ra, vecs[i].rb, vecs[i].ia, vecs[i].oa,
             vecs[i].ib, vecs[i].ob, vecs[i].exp_b, vecs[i].exp_res);
    end

    // Request from B while A's operation is in flight is ignored.
    bus.req_a = 1'b1; bus.in_a = 8'd20; bus.op_a = 2'd1;
    @(negedge clk);
    check("bz_ack_a", bus.ack_a, 1);
    bus.req_a = 1'b0;
    @(negedge clk);                          // EXEC
    bus.req_b = 1'b1; bus.in_b = 8'd1; bus.op_b = 2'd0;
    @(negedge clk);                          // CAPT
    check("bz_ack_b_capt", bus.ack_b, 0);
    bus.req_b = 1'b0;
    @(negedge clk);
    check("bz_done", {bus.done_a, bus.done_b}, 2'b10);
    check("bz_res", bus.result, 22);
    repeat (4) begin
      @(negedge clk);
      check("bz_quiet", {bus.ack_b, bus.done_b, bus.busy}, 0);
    end

    // Reset during EXEC aborts the operation.
    bus.req_a = 1'b1; bus.in_a = 8'd9; bus.op_a = 2'd0;
    @(negedge clk);
    check("ra_ack_a", bus.ack_a, 1);
    bus.req_a = 1'b0;
    @(negedge clk);                          // EXEC
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ra_busy", bus.busy, 0);
    check("ra_result", bus.result, 0);
    repeat (4) begin
      @(negedge clk);
      check("ra_no_done", {bus.done_a, bus.done_b}, 0);
    end

    // Continuous requests from both: A,B,A,B at 4-cycle spacing.
    bus.req_a = 1'b1; bus.in_a = 8'd1; bus.op_a = 2'd0;
    bus.req_b = 1'b1; bus.in_b = 8'd2; bus.op_b = 2'd0;
    rr_n = 0;
    overlap = 0;
    for (int c = 0; c < 40 && rr_n < 4; c++) begin
      @(negedge clk);
      if ((bus.ack_a && bus.ack_b) || (bus.done_a && bus.done_b)) overlap++;
      if (bus.done_a || bus.done_b) begin
        rr_who[rr_n] = bus.done_b;
        rr_res[rr_n] = bus.result;
        rr_cyc[rr_n] = c;
        rr_n++;
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    check("rr_count", rr_n, 4);
    check("rr_overlap", overlap, 0);
    if (rr_n == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("rr_who", rr_who[k], k % 2);
        check("rr_res", rr_res[k], (k % 2) ? 2 : 1);
      end
      check("rr_spacing", rr_cyc[3] - rr_cyc[0], 12);
    end

    // Normal service after the aborted operation.
    idle_inputs();
    do_txn(1'b1, 1'b0, 8'd3, 2'd1, 8'd0, 2'd0, 1'b0, 9'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clock  input  1  sole clock; all state changes on posedge clock.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on posedge clock only.
REQ-003 req_a  input  1  requester A wants an operation; held with in_a/op_a stable until ack_a.
REQ-004 in_a  input  8  requester A operand.
REQ-005 op_a  input  2  requester A opcode (0 pass, 1 add 2, 2 shift left 1, 3 popcount).
REQ-006 ack_a  output  1  one-cycle pulse; A's request accepted and operands latched.
REQ-007 done_a  output  1  one-cycle pulse; result holds A's answer.
REQ-008 req_b, in_b[7:0], op_b[1:0], ack_b, done_b  same as A, for requester B.
REQ-009 result  output  9  last completed result; holds until next completion.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 dp_in  output  8  operand to shared datapath (datapath registers it one cycle).
REQ-012 dp_op  output  2  opcode to shared datapath (unregistered in datapath, applied at the output-register edge).
REQ-013 dp_out  input  9  shared datapath registered output.

Function
REQ-014 The block SHALL run FSM states IDLE, ISSUE, EXEC, CAPT, in that order, returning CAPT -> IDLE unconditionally.
REQ-015 In IDLE with req_a or req_b high, the block SHALL grant one requester at the edge: latch its operand/opcode, assert its ack for the following cycle, record owner, go to ISSUE.
REQ-016 With exactly one request, that requester SHALL be granted.
REQ-017 With both requests, the requester not granted last SHALL be granted (round-robin); last-grant pointer updates only on grant.
REQ-018 The non-granted request SHALL stay pending (no ack) and be considered again on the next IDLE cycle.
REQ-019 dp_in SHALL equal the latched operand and dp_op the latched opcode in ISSUE, EXEC and CAPT; in IDLE both SHALL hold their previous values.
REQ-020 ISSUE -> EXEC at the next edge (datapath captures dp_in); EXEC -> CAPT at the next edge (datapath output valid in CAPT).
REQ-021 At the CAPT -> IDLE edge, result SHALL load dp_out and done of the owner SHALL assert for exactly one cycle.
REQ-022 Latency: grant edge E0, done/result visible after edge E3; one operation per 4 cycles minimum (next grant earliest at E4).
REQ-023 Requests, in_x, op_x changing after ack SHALL NOT affect the operation in flight.
REQ-024 ack_x and done_x SHALL never assert for both requesters in the same cycle; ack and done never for a non-owner.
REQ-025 req_x asserted while busy SHALL be ignored until IDLE (no ack, no queueing beyond the live req level).
REQ-026 result is the unmodified 9-bit dp_out; no arithmetic in this block.

Reset
REQ-027 While reset is high at an edge: state IDLE; ack_a, ack_b, done_a, done_b, busy 0; result 0; dp_in 0; dp_op 0; last-grant pointer = B (A wins first tie).
REQ-028 Reset during ISSUE/EXEC/CAPT SHALL abort the operation with no done pulse; result keeps value 0 from reset.
REQ-029 Requests high during reset SHALL not be granted until the first edge after reset deasserts.

Verification
REQ-030 Single: req_a=1, in_a=9, op_a=1 in IDLE -> ack_a pulse after E0, done_a pulse with result=11 after E3, busy high E0..E3.
REQ-031 Tie after reset: req_a (in 9, op 2) and req_b (in 143, op 3) together -> A first, result 18; B granted at E4, result 5 after E7.
REQ-032 Round-robin: A and B both requesting continuously, op 0, in_a=1, in_b=2 -> done order A,B,A,B; results 1,2,1,2.
REQ-033 Operand change: req_b in_b=15 op_b=3, change in_b to 0 cycle after ack_b -> result 4.
REQ-034 Reset mid-op: grant A (in 9 op 0), reset high in EXEC -> no done_a, result 0, busy 0, next request served normally.
REQ-035 Busy ignore: req_b raised in EXEC of A's op and dropped before CAPT -> no ack_b, no done_b.
